// File: rtl/orion_tlm_pkg.sv
// Shared types and frame layout for the ORION ADC telemetry framer.
// ORION_TLM_CHECKSUM_EN selects the 8-word frame with a trailing sum word.
package orion_tlm_pkg;

  typedef enum logic [1:0] {IDLE, REQ, REL, SEND} tlm_state_e;

  localparam logic [3:0] HDR_TAG     = 4'hA;
  localparam int         NUM_CH      = 6;
  localparam int         SEQ_W       = 8;
  localparam int         WIDX_W      = 3;
  localparam int         HDR_TAG_MSB = 15;
  localparam int         HDR_TAG_LSB = 12;
  localparam int         HDR_OVR_BIT = 11;
  localparam int         HDR_TMO_BIT = 10;

`ifdef ORION_TLM_CHECKSUM_EN
  localparam int FRAME_WORDS = 8;
`else
  localparam int FRAME_WORDS = 7;
`endif

  function automatic logic [15:0] mk_hdr(input logic ovr, input logic tmo,
                                         input logic [SEQ_W-1:0] seq);
    logic [15:0] h;
    h = '0;
    h[HDR_TAG_MSB:HDR_TAG_LSB] = HDR_TAG;
    h[HDR_OVR_BIT]             = ovr;
    h[HDR_TMO_BIT]             = tmo;
    h[SEQ_W-1:0]               = seq;
    return h;
  endfunction

endpackage

// File: rtl/orion_adc_telemetry_if.sv
// Telemetry word stream towards the Tx FIFO control (valid/ready, last marks frame end).
interface orion_adc_telemetry_if;
  logic [15:0] tlm_data;
  logic        tlm_valid;
  logic        tlm_ready;
  logic        tlm_last;

  modport master (output tlm_data, output tlm_valid, output tlm_last, input tlm_ready);
  modport slave  (input tlm_data, input tlm_valid, input tlm_last, output tlm_ready);
endinterface

// File: rtl/orion_tlm_timer.sv
// Free-running frame period counter plus a restartable ack-timeout down-counter.
module orion_tlm_timer #(
  parameter int PERIOD_CLKS = 30720,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic clock,
  input  logic nreset,
  input  logic i_tmo_start,
  output logic o_wrap,
  output logic o_tmo_expired
);
  localparam int PW = $clog2(PERIOD_CLKS);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [PW-1:0] r_per;
  logic [TW-1:0] r_tmo;

  assign o_wrap        = (r_per == PW'(PERIOD_CLKS - 1));
  assign o_tmo_expired = (r_tmo == '0);

  // Loaded on the edge that enters a waiting state, so expiry lands in its ACK_TIMEOUT-th cycle.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_per <= '0;
      r_tmo <= '0;
    end else begin
      r_per <= o_wrap ? '0 : r_per + 1'b1;
      if (i_tmo_start)      r_tmo <= TW'(ACK_TIMEOUT - 1);
      else if (r_tmo != '0) r_tmo <= r_tmo - 1'b1;
    end
  end
endmodule

// File: rtl/orion_adc_telemetry.sv
// Peak-detect reset/ack handshake and per-period framing of the six slow-ADC channels.
// Define ORION_TLM_CHECKSUM_EN to append a mod-2^16 sum of w0..w6 as the last word.
module orion_adc_telemetry
  import orion_tlm_pkg::*;
#(
  parameter int PERIOD_CLKS = 30720,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic [11:0]           AIN1,
  input  logic [11:0]           AIN2,
  input  logic [11:0]           AIN3,
  input  logic [11:0]           AIN4,
  input  logic [11:0]           AIN5,
  input  logic [11:0]           AIN6,
  input  logic                  pk_detect_ack,
  output logic                  pk_detect_reset,
  orion_adc_telemetry_if.master tlm,
  output logic                  tlm_overrun,
  output logic                  tlm_timeout
);
  tlm_state_e              r_state, w_state_nxt;
  logic                    r_pend, r_ack_hi, r_ovr_f, r_tmo_f, r_hdr_ovr;
  logic                    r_ovr_sticky, r_tmo_sticky;
  logic [SEQ_W-1:0]        r_seq;
  logic [NUM_CH-1:0][11:0] r_snap;
  logic                    r_valid, r_last;
  logic [15:0]             r_data;
  logic [WIDX_W-1:0]       r_widx, w_nidx;
  logic [15:0]             w_word;
  logic                    w_wrap, w_tmo_exp, w_tmo_start;
  logic                    w_take, w_snap_en, w_tmo_evt, w_ovr_evt;
  logic                    w_hs, w_last_hs, w_load;

  orion_tlm_timer #(.PERIOD_CLKS(PERIOD_CLKS), .ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clock         (clock),
    .nreset        (nreset),
    .i_tmo_start   (w_tmo_start),
    .o_wrap        (w_wrap),
    .o_tmo_expired (w_tmo_exp)
  );

  assign w_hs        = r_valid && tlm.tlm_ready;
  assign w_last_hs   = w_hs && r_last;
  assign w_tmo_start = (w_state_nxt != r_state);
  assign w_ovr_evt   = w_wrap && (r_pend || (r_state != IDLE));

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_snap_en   = 1'b0;
    w_tmo_evt   = 1'b0;
    case (r_state)
      IDLE: if (r_pend && enable) begin
        w_take      = 1'b1;
        w_state_nxt = REQ;
      end
      REQ: if (pk_detect_ack) begin
        w_snap_en   = 1'b1;
        w_state_nxt = REL;
      end else if (w_tmo_exp) begin
        w_snap_en   = 1'b1;
        w_tmo_evt   = 1'b1;
        w_state_nxt = REL;
      end
      // Release waits for the falling ack edge; an ack that never rose must time out here too.
      REL: if (!pk_detect_ack && r_ack_hi) begin
        w_state_nxt = SEND;
      end else if (w_tmo_exp) begin
        w_tmo_evt   = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: if (w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output word register: first SEND cycle loads w0, each non-final handshake loads the next.
  assign w_nidx = r_valid ? r_widx + 1'b1 : '0;
  assign w_load = (r_state == SEND) && (!r_valid || (w_hs && !r_last));

`ifdef ORION_TLM_CHECKSUM_EN
  logic [15:0] r_sum;
`endif

  always_comb begin
    case (w_nidx)
      3'd0:    w_word = mk_hdr(r_ovr_f, r_tmo_f, r_seq);
`ifdef ORION_TLM_CHECKSUM_EN
      3'd7:    w_word = r_sum;
`else
      3'd7:    w_word = '0;
`endif
      default: w_word = {1'b0, w_nidx, r_snap[w_nidx - 3'd1]};
    endcase
  end

`ifdef ORION_TLM_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!nreset)                                          r_sum <= '0;
    else if (w_load && (w_nidx == 3'd0))                  r_sum <= w_word;
    else if (w_load && (w_nidx < 3'(FRAME_WORDS - 1)))    r_sum <= r_sum + w_word;
  end
`endif

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_pend       <= 1'b0;
      r_ack_hi     <= 1'b0;
      r_ovr_f      <= 1'b0;
      r_tmo_f      <= 1'b0;
      r_hdr_ovr    <= 1'b0;
      r_ovr_sticky <= 1'b0;
      r_tmo_sticky <= 1'b0;
      r_seq        <= '0;
      r_snap       <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_data       <= '0;
      r_widx       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend       <= (r_pend && !w_take) || w_wrap;
      r_ovr_sticky <= r_ovr_sticky || w_ovr_evt;
      r_tmo_sticky <= r_tmo_sticky || w_tmo_evt;
      r_tmo_f      <= (r_tmo_f && !w_last_hs) || w_tmo_evt;
      // Only the overrun already reported in this header is retired; later ones carry forward.
      r_ovr_f      <= (r_ovr_f && !(w_last_hs && r_hdr_ovr)) || w_ovr_evt;
      if (r_state == REQ) r_ack_hi <= pk_detect_ack;
      if (w_snap_en)      r_snap   <= {AIN6, AIN5, AIN4, AIN3, AIN2, AIN1};
      if (w_last_hs)      r_seq    <= r_seq + 1'b1;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_widx  <= w_nidx;
        r_last  <= (w_nidx == 3'(FRAME_WORDS - 1));
        if (w_nidx == 3'd0) r_hdr_ovr <= r_ovr_f;
      end else if (w_last_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign pk_detect_reset = (r_state == REQ);
  assign tlm.tlm_data    = r_data;
  assign tlm.tlm_valid   = r_valid;
  assign tlm.tlm_last    = r_last;
  assign tlm_overrun     = r_ovr_sticky;
  assign tlm_timeout     = r_tmo_sticky;
endmodule

// File: tb/tb_orion_adc_telemetry.sv
// Scoreboard bench for orion_adc_telemetry: frame-level reference model, randomized ADC data/ready.
module tb_orion_adc_telemetry;
  localparam int P  = 600;
  localparam int AT = 100;
  localparam int D  = 81;
`ifdef ORION_TLM_CHECKSUM_EN
  localparam int NW = 8;
`else
  localparam int NW = 7;
`endif

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        enable = 1'b0;
  logic        ack = 1'b0;
  logic [11:0] ain [6];
  logic        pk, ovr_o, tmo_o;

  orion_adc_telemetry_if tlm_if();

  orion_adc_telemetry #(.PERIOD_CLKS(P), .ACK_TIMEOUT(AT)) dut (
    .clock(clock), .nreset(nreset), .enable(enable),
    .AIN1(ain[0]), .AIN2(ain[1]), .AIN3(ain[2]), .AIN4(ain[3]), .AIN5(ain[4]), .AIN6(ain[5]),
    .pk_detect_ack(ack), .pk_detect_reset(pk), .tlm(tlm_if),
    .tlm_overrun(ovr_o), .tlm_timeout(tmo_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus drivers ----------------
  bit ack_tied = 0, ain_dir = 0;
  int rdy_mode = 1, rdy_ph = 0, rd_cnt = 0;

  initial for (int i = 0; i < 6; i++) ain[i] = '0;

  always @(negedge clock) begin
    if (pk) begin
      rd_cnt++;
      ack = !ack_tied && (rd_cnt >= D);
    end else begin
      rd_cnt = 0;
      ack = 1'b0;
      for (int i = 0; i < 6; i++) ain[i] = 12'($urandom_range(0, 4095));
      if (ain_dir) begin
        ain[0] = 12'h7FF;
        ain[5] = 12'h0D2;
      end
    end
    case (rdy_mode)
      0:       tlm_if.tlm_ready = 1'b0;
      2:       tlm_if.tlm_ready = (rdy_ph == 0);
      3:       tlm_if.tlm_ready = 1'($urandom_range(0, 1));
      default: tlm_if.tlm_ready = 1'b1;
    endcase
    rdy_ph = (rdy_ph + 1) % 3;
  end

  // ---------------- reference model + monitor ----------------
  typedef struct { logic [15:0] d; logic l; } wexp_t;
  wexp_t exp_q[$];
  int   m_cnt = 0, m_seq = 0, m_frames = 0, lf_idx = 0, pk_len = 0, gap = 0;
  bit   m_pend = 0, m_busy = 0, m_ovr = 0, m_hdr_ovr = 0, m_ovr_st = 0, m_tmo_st = 0;
  bit   cur_tied = 0, rst_prev = 0, prev_vnr = 0, prev_pk = 0, gap_on = 0, exp_rise = 0;
  logic [15:0] prev_d;
  logic        prev_l;
  logic [15:0] last_frame [8];

  always @(negedge clock) begin
    bit hs, endf, wrap, start, evt;
    wexp_t e;
    logic [15:0] w, sum;
    #1;
    if (rst_prev) begin
      chk("rst_pk", pk, 0);
      chk("rst_valid", tlm_if.tlm_valid, 0);
      chk("rst_data", tlm_if.tlm_data, 0);
      chk("rst_last", tlm_if.tlm_last, 0);
      chk("rst_overrun", ovr_o, 0);
      chk("rst_timeout", tmo_o, 0);
    end
    if (!nreset) begin
      m_cnt = 0; m_seq = 0; m_pend = 0; m_busy = 0; m_ovr = 0; m_hdr_ovr = 0;
      m_ovr_st = 0; m_tmo_st = 0; exp_q.delete(); lf_idx = 0;
      prev_vnr = 0; prev_pk = 0; pk_len = 0; gap_on = 0; exp_rise = 0;
    end else begin
      chk("overrun_sticky", ovr_o, m_ovr_st);
      if (exp_rise) chk("req_start", pk, 1);
      else if (pk && !prev_pk) chk("req_spurious", pk, 0);
      exp_rise = 0;
      // peak request length and REL+first-SEND gap
      if (pk) pk_len = prev_pk ? pk_len + 1 : 1;
      if (prev_pk && !pk) begin
        chk("req_len", pk_len, cur_tied ? AT : D);
        gap_on = 1; gap = 0;
      end
      if (gap_on) begin
        if (tlm_if.tlm_valid) begin
          chk("first_word_gap", gap, (cur_tied ? AT : 1) + 1);
          gap_on = 0;
        end else gap++;
      end
      if (prev_vnr && tlm_if.tlm_valid) begin
        chk("hold_data", tlm_if.tlm_data, prev_d);
        chk("hold_last", tlm_if.tlm_last, prev_l);
      end
      hs = tlm_if.tlm_valid && tlm_if.tlm_ready;
      endf = 0;
      if (hs) begin
        if (exp_q.size() == 0) chk("unexpected_word", tlm_if.tlm_data, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("word", tlm_if.tlm_data, e.d);
          chk("last", tlm_if.tlm_last, e.l);
          if (lf_idx < 8) last_frame[lf_idx] = tlm_if.tlm_data;
          lf_idx++;
          endf = e.l;
          if (e.l) begin lf_idx = 0; m_frames++; end
        end
      end
      // frame-level rules for the upcoming clock edge
      wrap  = (m_cnt == P - 1);
      start = !m_busy && m_pend && enable;
      evt   = wrap && (m_pend || m_busy);
      if (start) begin
        cur_tied  = ack_tied;
        m_hdr_ovr = m_ovr;
        if (ack_tied) m_tmo_st = 1;
        w = 16'hA000 | (m_ovr ? 16'h0800 : 16'h0) | (ack_tied ? 16'h0400 : 16'h0) | 16'(m_seq);
        sum = w;
        exp_q.push_back('{w, 1'b0});
        for (int n = 1; n <= 6; n++) begin
          w = 16'(n * 4096) + 16'(ain[n-1]);
          sum = sum + w;
          exp_q.push_back('{w, 1'b0});
        end
        if (NW == 8) exp_q.push_back('{sum, 1'b0});
        e = exp_q.pop_back();
        e.l = 1'b1;
        exp_q.push_back(e);
        exp_rise = 1;
      end
      if (endf) begin
        m_seq = (m_seq + 1) % 256;
        if (m_hdr_ovr) m_ovr = 0;
      end
      if (evt) begin m_ovr = 1; m_ovr_st = 1; end
      m_pend = (m_pend && !start) || wrap;
      m_busy = (m_busy && !endf) || start;
      m_cnt  = wrap ? 0 : m_cnt + 1;
      prev_vnr = tlm_if.tlm_valid && !tlm_if.tlm_ready;
      prev_d   = tlm_if.tlm_data;
      prev_l   = tlm_if.tlm_last;
      prev_pk  = pk;
    end
    rst_prev = !nreset;
  end

  // ---------------- sequence ----------------
  task automatic wait_frames(input int n, input int budget);
    int tgt = m_frames + n;
    int c = 0;
    while (m_frames < tgt && c < budget) begin @(negedge clock); c++; end
    chk("frame_wait_done", (m_frames >= tgt), 1);
  endtask

  task automatic wait_sig(input bit use_pk, input int budget);
    int c = 0;
    while (!(use_pk ? pk : tlm_if.tlm_valid) && c < budget) begin @(negedge clock); c++; end
    chk(use_pk ? "wait_req" : "wait_valid", 32'(use_pk ? pk : tlm_if.tlm_valid), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clock); nreset = 1'b0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
  endtask

  initial begin
    tlm_if.tlm_ready = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clock);
    nreset = 1'b1;
    // normal frames, seq 0..2
    wait_frames(3, 4 * P);
    // directed channel values on the seq=3 frame
    ain_dir = 1;
    wait_frames(1, 2 * P);
    ain_dir = 0;
    chk("dir_w0", last_frame[0], 16'hA003);
    chk("dir_w1", last_frame[1], 16'h17FF);
    chk("dir_w6", last_frame[6], 16'h60D2);
    // ack stuck low: both waits time out, then recovery
    chk("timeout_before", tmo_o, 0);
    ack_tied = 1;
    wait_frames(1, 2 * P);
    ack_tied = 0;
    chk("timeout_sticky", tmo_o, m_tmo_st);
    chk("timeout_set", tmo_o, 1);
    wait_frames(1, 2 * P);
    // sink stalled across two periods
    rdy_mode = 0;
    wait_sig(0, 2 * P);
    repeat (2 * P) @(negedge clock);
    chk("overrun_set", ovr_o, 1);
    rdy_mode = 1;
    wait_frames(2, 3 * P);
    repeat (10) @(negedge clock);
    chk("no_extra_frame", {pk, tlm_if.tlm_valid}, 0);
    // sparse and random ready
    rdy_mode = 2;
    wait_frames(2, 3 * P);
    rdy_mode = 3;
    wait_frames(2, 3 * P);
    // enable low holds the pending request
    enable = 1'b0;
    repeat (P + P / 2) @(negedge clock);
    chk("disabled_idle", {pk, tlm_if.tlm_valid}, 0);
    enable = 1'b1;
    wait_frames(2, 3 * P);
    // reset during SEND, then during REQ
    rdy_mode = 0;
    wait_sig(0, 2 * P);
    pulse_reset();
    rdy_mode = 1;
    wait_frames(1, 2 * P);
    wait_sig(1, 2 * P);
    repeat (10) @(negedge clock);
    pulse_reset();
    wait_frames(1, 2 * P);
    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
